// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-port, byte-addressed
// memory between instruction fetch (IF) and load/store (LS).
// Optional feature macro: MEM_ARB_RMW_EN enables read-modify-write for
// byte/half stores. Without it, sub-word stores are rejected with ls_err.
//
// Handshake: a requester raises *_req with its fields stable and holds them
// until the matching one-cycle *_ack. The requester drops req during the ack
// cycle. Once granted, a transaction always completes, even if req falls.
// The ungranted side simply waits.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_rw,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_ack,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,
    output logic                  mem_op,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_w,
    input  logic [DATA_WIDTH-1:0] mem_data_r,
    output logic                  busy
);

`ifdef MEM_ARB_RMW_EN
    typedef enum logic [2:0] {S_IDLE, S_ACC, S_RD, S_WR, S_RESP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ACC, S_RESP} state_t;
`endif

    state_t                  state_q, state_d;
    logic                    rr_ls_q, rr_ls_d;     // 1: LS wins a tie, 0: IF wins
    logic                    gnt_ls_q, gnt_ls_d;   // side currently granted
    logic                    rw_q, rw_d;
    logic [1:0]              size_q, size_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;       // captured read or merged word
`ifdef MEM_ARB_RMW_EN
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   merged;
`endif
    logic                    mem_op_q, mem_op_d;
    logic                    mem_rw_q, mem_rw_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_w_q, mem_data_w_d;
    logic                    if_ack_q, if_ack_d;
    logic                    ls_ack_q, ls_ack_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
    logic                    ls_err_q, ls_err_d;
    logic                    busy_q, busy_d;

    logic                    pick_ls;
    logic                    sub_store;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Grant selection and request decode from the live request inputs.
    always_comb begin
        pick_ls   = ls_req && (!if_req || rr_ls_q);
        sub_store = pick_ls && ls_rw && !ls_size[1];
    end

    // Zero-extend load data to the latched access size (size 3 acts as word).
    always_comb begin
        case (size_q)
            2'd0:    load_ext = {{(DATA_WIDTH-8){1'b0}},  data_q[7:0]};
            2'd1:    load_ext = {{(DATA_WIDTH-16){1'b0}}, data_q[15:0]};
            default: load_ext = data_q;
        endcase
    end

`ifdef MEM_ARB_RMW_EN
    // Splice the low byte/half of the store data into the word read back.
    always_comb begin
        if (size_q == 2'd0) begin
            merged = {mem_data_r[DATA_WIDTH-1:8], wdata_q[7:0]};
        end else begin
            merged = {mem_data_r[DATA_WIDTH-1:16], wdata_q[15:0]};
        end
    end
`endif

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        rr_ls_d      = rr_ls_q;
        gnt_ls_d     = gnt_ls_q;
        rw_d         = rw_q;
        size_d       = size_q;
        err_d        = err_q;
        data_d       = data_q;
`ifdef MEM_ARB_RMW_EN
        wdata_d      = wdata_q;
`endif
        mem_op_d     = 1'b0;
        mem_rw_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_w_d = mem_data_w_q;
        if_ack_d     = 1'b0;
        ls_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        ls_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || ls_req) begin
                    gnt_ls_d = pick_ls;
                    rw_d     = pick_ls && ls_rw;
                    size_d   = ls_size;
                    err_d    = 1'b0;
                    if (sub_store) begin
`ifdef MEM_ARB_RMW_EN
                        // Read the target word first, write the merge next.
                        wdata_d    = ls_wdata;
                        mem_addr_d = ls_addr;
                        mem_op_d   = 1'b1;
                        state_d    = S_RD;
`else
                        // Unsupported without RMW: reject, no memory access.
                        err_d   = 1'b1;
                        state_d = S_RESP;
`endif
                    end else begin
                        mem_addr_d = pick_ls ? ls_addr : if_addr;
                        if (pick_ls && ls_rw) begin
                            mem_data_w_d = ls_wdata;
                        end
                        mem_op_d = 1'b1;
                        mem_rw_d = pick_ls && ls_rw;
                        state_d  = S_ACC;
                    end
                end
            end
            S_ACC: begin
                data_d  = mem_data_r;
                state_d = S_RESP;
            end
`ifdef MEM_ARB_RMW_EN
            S_RD: begin
                data_d       = merged;
                mem_data_w_d = merged;
                mem_op_d     = 1'b1;
                mem_rw_d     = 1'b1;
                state_d      = S_WR;
            end
            S_WR: begin
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                if_ack_d = !gnt_ls_q;
                ls_ack_d = gnt_ls_q;
                if (gnt_ls_q) begin
                    ls_rdata_d = rw_q ? '0 : load_ext;
                    ls_err_d   = err_q;
                end else begin
                    if_rdata_d = data_q;
                end
                // The side just served loses the next tie.
                rr_ls_d = !gnt_ls_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // All state and outputs registered; synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q      <= S_IDLE;
            rr_ls_q      <= 1'b0;
            gnt_ls_q     <= 1'b0;
            rw_q         <= 1'b0;
            size_q       <= 2'd0;
            err_q        <= 1'b0;
            data_q       <= '0;
`ifdef MEM_ARB_RMW_EN
            wdata_q      <= '0;
`endif
            mem_op_q     <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_w_q <= '0;
            if_ack_q     <= 1'b0;
            ls_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            ls_err_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ls_q      <= rr_ls_d;
            gnt_ls_q     <= gnt_ls_d;
            rw_q         <= rw_d;
            size_q       <= size_d;
            err_q        <= err_d;
            data_q       <= data_d;
`ifdef MEM_ARB_RMW_EN
            wdata_q      <= wdata_d;
`endif
            mem_op_q     <= mem_op_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_w_q <= mem_data_w_d;
            if_ack_q     <= if_ack_d;
            ls_ack_q     <= ls_ack_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign ls_ack     = ls_ack_q;
    assign ls_rdata   = ls_rdata_q;
    assign ls_err     = ls_err_q;
    assign mem_op     = mem_op_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_w = mem_data_w_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural negedge-sampling Mem.
module tb_mem_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_rw = 1'b0;
    logic [1:0]  ls_size = 2'd2;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_op;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_rw      (ls_rw),
        .ls_size    (ls_size),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_ack     (ls_ack),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .mem_op     (mem_op),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_data_w (mem_data_w),
        .mem_data_r (mem_data_r),
        .busy       (busy)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    // Mem model: little-endian bytes, acts on negedge, 512-byte wrap.
    logic [7:0]  mem [0:511];
    logic [31:0] rd_word;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          ack_cnt = 0;
    int          both_cnt = 0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h37; mem[1] = 8'h55; mem[2] = 8'h34; mem[3] = 8'h12;
    end

    always @(negedge sys_clk) begin
        if (mem_op === 1'b1) begin
            if (mem_rw === 1'b1) begin
                for (int i = 0; i < 4; i++) mem[9'(mem_addr[8:0] + 9'(i))] = mem_data_w[8*i +: 8];
                wr_cnt++;
            end else begin
                for (int i = 0; i < 4; i++) rd_word[8*i +: 8] = mem[9'(mem_addr[8:0] + 9'(i))];
                mem_data_r = rd_word;
                rd_cnt++;
            end
        end
        if (if_ack === 1'b1 && ls_ack === 1'b1) both_cnt++;
        if (if_ack === 1'b1 || ls_ack === 1'b1) ack_cnt++;
    end

    // Scoreboard for round-robin ack order: {tick index, side(0=IF,1=LS)}
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Driver: one LS transaction, bounded wait for ls_ack, req dropped in the ack cycle.
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;

    task automatic ls_txn(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
        ls_rw = rw; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
        got_lat = 0;
        do begin
            tick();
            got_lat++;
        end while (ls_ack !== 1'b1 && got_lat < 12);
        got_rdata = ls_rdata;
        got_err   = ls_err;
        ls_req    = 1'b0;
    endtask

    int a0, w0, t0;

    initial begin
        // Reset with both requests high: everything stays zero.
        sys_rst = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_ctrl", {26'd0, mem_op, mem_rw, if_ack, ls_ack, ls_err, busy}, 32'd0);
            check("rst_addr", mem_addr | mem_data_w | if_rdata | ls_rdata, 32'd0);
        end

        // IF read of address 0: ack two edges after the grant edge.
        ls_req = 1'b0; if_addr = 32'h0; sys_rst = 1'b1;
        tick();
        check("if_acc_op", {30'd0, mem_op, busy}, 32'd3);
        check("if_acc_addr", mem_addr, 32'h0);
        tick();
        check("if_resp_op", {30'd0, mem_op, if_ack}, 32'd0);
        tick();
        check("if_ack", {31'd0, if_ack}, 32'd1);
        check("if_rdata", if_rdata, 32'h12345537);
        check("if_idle_busy", {31'd0, busy}, 32'd0);
        if_req = 1'b0;
        tick();
        check("if_ack_pulse", {31'd0, if_ack}, 32'd0);

        // Both requests held from reset: IF, LS, IF, LS at ticks 3,6,9,12.
        sys_rst = 1'b0;
        tick();
        sys_rst = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        ls_rw = 1'b0; ls_size = 2'd2; ls_addr = 32'h0; if_addr = 32'h0;
        exp_q.push_back({7'd3, 1'b0});
        exp_q.push_back({7'd6, 1'b1});
        exp_q.push_back({7'd9, 1'b0});
        exp_q.push_back({7'd12, 1'b1});
        a0 = ack_cnt;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (if_ack === 1'b1) got_q.push_back({7'(k), 1'b0});
            if (ls_ack === 1'b1) begin
                got_q.push_back({7'(k), 1'b1});
                check("rr_ls_rdata", ls_rdata, 32'h12345537);
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();
        check("rr_ack_cycles", 32'(ack_cnt - a0), 32'd4);
        check("rr_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check("rr_order", {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
        check("rr_idle", {30'd0, busy, mem_op}, 32'd0);

        // Word store then loads at 0x100.
        ls_txn(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        check("st_lat", 32'(got_lat), 32'd3);
        check("st_err", {31'd0, got_err}, 32'd0);
        tick();
        ls_txn(1'b0, 2'd2, 32'h100, 32'h0);
        check("ldw_lat", 32'(got_lat), 32'd3);
        check("ldw_data", got_rdata, 32'hDEADBEEF);
        check("ldw_err", {31'd0, got_err}, 32'd0);
        tick();
        ls_txn(1'b0, 2'd0, 32'h100, 32'h0);
        check("ldb_data", got_rdata, 32'h000000EF);
        tick();
        ls_txn(1'b0, 2'd1, 32'h102, 32'h0);
        check("ldh_data", got_rdata, 32'h0000DEAD);
        tick();
        ls_txn(1'b0, 2'd3, 32'h100, 32'h0);
        check("ld3_data", got_rdata, 32'hDEADBEEF);
        tick();

        // Byte store 0xAA at 0x101.
        w0 = wr_cnt; t0 = rd_cnt;
        ls_txn(1'b1, 2'd0, 32'h101, 32'h123456AA);
`ifdef MEM_ARB_RMW_EN
        check("rmw_lat", 32'(got_lat), 32'd4);
        check("rmw_err", {31'd0, got_err}, 32'd0);
        check("rmw_rd_cycles", 32'(rd_cnt - t0), 32'd1);
        check("rmw_wr_cycles", 32'(wr_cnt - w0), 32'd1);
        tick();
        ls_txn(1'b0, 2'd2, 32'h100, 32'h0);
        check("rmw_ld", got_rdata, 32'hDEADAAEF);
        tick();
        ls_txn(1'b1, 2'd1, 32'h102, 32'h00009876);
        check("rmw_half_err", {31'd0, got_err}, 32'd0);
        tick();
        ls_txn(1'b0, 2'd2, 32'h100, 32'h0);
        check("rmw_half_ld", got_rdata, 32'h9876AAEF);
`else
        check("nrmw_lat", 32'(got_lat), 32'd2);
        check("nrmw_err", {31'd0, got_err}, 32'd1);
        check("nrmw_mem_cycles", 32'(wr_cnt - w0 + rd_cnt - t0), 32'd0);
        tick();
        w0 = wr_cnt;
        ls_txn(1'b1, 2'd1, 32'h102, 32'h00009876);
        check("nrmw_half_err", {31'd0, got_err}, 32'd1);
        check("nrmw_half_wr", 32'(wr_cnt - w0), 32'd0);
        tick();
        ls_txn(1'b0, 2'd2, 32'h100, 32'h0);
        check("nrmw_ld", got_rdata, 32'hDEADBEEF);
        check("nrmw_ld_err", {31'd0, got_err}, 32'd0);
`endif
        tick();

        // Reset during ACC of a load: no ack afterwards.
        ls_rw = 1'b0; ls_size = 2'd2; ls_addr = 32'h100; ls_req = 1'b1;
        tick();
        check("rstacc_op", {31'd0, mem_op}, 32'd1);
        sys_rst = 1'b0;
        a0 = ack_cnt;
        tick();
        check("rstacc_idle", {30'd0, mem_op, busy}, 32'd0);
        ls_req = 1'b0; sys_rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rstacc_noack", 32'(ack_cnt - a0), 32'd0);

`ifdef MEM_ARB_RMW_EN
        // Reset during RD of a byte store: the write never happens.
        ls_rw = 1'b1; ls_size = 2'd0; ls_addr = 32'h100; ls_wdata = 32'h55; ls_req = 1'b1;
        w0 = wr_cnt;
        tick();
        check("rstrd_rd", {30'd0, mem_op, mem_rw}, 32'd2);
        sys_rst = 1'b0;
        a0 = ack_cnt;
        tick();
        check("rstrd_idle", {30'd0, mem_op, busy}, 32'd0);
        ls_req = 1'b0; sys_rst = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("rstrd_noack", 32'(ack_cnt - a0), 32'd0);
        check("rstrd_nowr", 32'(wr_cnt - w0), 32'd0);
        ls_txn(1'b0, 2'd2, 32'h100, 32'h0);
        check("rstrd_ld", got_rdata, 32'h9876AAEF);
        tick();
`endif

        check("never_both_acks", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
